// File: rtl/fifo_stream_reader.sv
// Read-side master for a sync FIFO: issues pops, absorbs the 1-cycle read latency,
// and re-presents the words as a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  underflow_err,
  input  logic                  clear_err
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] tail;
  logic                  pop;
  logic [1:0]            pending;
  logic [1:0]            occ_nxt;

  assign pop     = m_valid & m_ready;
  assign pending = occ + 2'(inflight);
  assign occ_nxt = pending - 2'(pop);

  // Combinational from m_ready so a slot freed this cycle can be refilled at once.
  assign fifo_rd_en = !rst & enable & !fifo_empty & (occ_nxt < 2'd2);

  // m_data is the buffer head; tail holds the second entry when occ == 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ           <= 2'd0;
      inflight      <= 1'b0;
      tail          <= '0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      beat_count    <= '0;
      underflow_err <= 1'b0;
    end else begin
      assert (!(inflight && occ == 2'd2));
      inflight <= fifo_rd_en;
      occ      <= occ_nxt;
      m_valid  <= (occ_nxt != 2'd0);
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) m_data <= fifo_dout;
          else             tail   <= fifo_dout;
        end
        2'b01: begin
          if (occ == 2'd2) m_data <= tail;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            m_data <= fifo_dout;
          end else begin
            m_data <= tail;
            tail   <= fifo_dout;
          end
        end
        default: ;
      endcase
      beat_count <= beat_count + CNT_WIDTH'(pop);
      // Set wins over clear.
      if (fifo_underflow)  underflow_err <= 1'b1;
      else if (clear_err)  underflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a small behavioural FIFO.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic [15:0] beat_count;
  logic        underflow_err;
  logic        clear_err;

  logic        rd_en4;
  logic        m_valid4;
  logic [15:0] m_data4;
  logic [3:0]  beat_count4;
  logic        underflow_err4;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:31];
  int          wp = 0;
  int          rp = 0;
  logic        flush;
  int          outstanding;

  always #5 clk = ~clk;

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .beat_count(beat_count),
    .underflow_err(underflow_err), .clear_err(clear_err)
  );

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_dout(fifo_dout), .fifo_rd_en(rd_en4),
    .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .beat_count(beat_count4),
    .underflow_err(underflow_err4), .clear_err(clear_err)
  );

  assign fifo_empty = (wp == rp);

  // Behavioural FIFO with 1-cycle registered read data.
  always @(posedge clk) begin
    if (flush) begin
      rp <= wp;
    end else if (fifo_rd_en && (rp != wp)) begin
      fifo_dout <= mem[rp % 32];
      rp        <= rp + 1;
    end
  end

  // Words requested but not yet accepted downstream (occ + inflight).
  always @(posedge clk or posedge rst) begin
    if (rst) outstanding <= 0;
    else     outstanding <= outstanding + int'(fifo_rd_en) - int'(m_valid & m_ready);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    mem[wp % 32] = d;
    wp = wp + 1;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush = 1'b1; enable = 1'b0; m_ready = 1'b0;
    clear_err = 1'b0; fifo_underflow = 1'b0;
    tick; tick;
    flush = 1'b0; rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b1; enable = 1'b1; m_ready = 1'b1;
    clear_err = 1'b0; fifo_underflow = 1'b0; fifo_dout = 16'h0;
    push(16'hBEEF);
    #2;
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 16'h0 ||
        beat_count !== 16'h0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rd_en=%b valid=%b data=%h cnt=%0d err=%b required all 0",
               fifo_rd_en, m_valid, m_data, beat_count, underflow_err);
    end
    do_reset;
  endtask

  task automatic test_stream;
    int first_rd = -1, last_rd = -1, rd_cnt = 0;
    int first_v = -1, last_v = -1, got = 0;
    logic [15:0] exp = 16'h0001;
    do_reset;
    for (int i = 1; i <= 8; i++) push(16'(i));
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c; rd_cnt++;
      end
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c; got++;
        checks++;
        if (m_data !== exp) begin
          errors++;
          $display("FAIL stream_data: got %h required %h", m_data, exp);
        end
        exp++;
      end
      tick;
    end
    checks++;
    if (rd_cnt != 8 || last_rd - first_rd != 7) begin
      errors++;
      $display("FAIL stream_rd_en: %0d pulses over span %0d, required 8 over 7", rd_cnt, last_rd - first_rd);
    end
    checks++;
    if (got != 8 || last_v - first_v != 7 || first_v - first_rd != 2) begin
      errors++;
      $display("FAIL stream_timing: %0d words, span %0d, latency %0d; required 8, 7, 2",
               got, last_v - first_v, first_v - first_rd);
    end
    checks++;
    if (beat_count !== 16'd8) begin
      errors++;
      $display("FAIL stream_count: got %0d required 8", beat_count);
    end
  endtask

  task automatic test_backpressure;
    int rd_cnt = 0, got = 0;
    logic [15:0] exp = 16'h0001;
    do_reset;
    for (int i = 1; i <= 8; i++) push(16'(i));
    enable = 1'b1; m_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (fifo_rd_en) rd_cnt++;
      if (c >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
          errors++;
          $display("FAIL hold_output: valid=%b data=%h required 1/0001", m_valid, m_data);
        end
      end
      tick;
    end
    checks++;
    if (rd_cnt != 2) begin
      errors++;
      $display("FAIL hold_rd_en: %0d pulses required 2", rd_cnt);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m_valid) begin
        got++;
        checks++;
        if (m_data !== exp) begin
          errors++;
          $display("FAIL drain_data: got %h required %h", m_data, exp);
        end
        exp++;
      end
      tick;
    end
    checks++;
    if (got != 8 || beat_count !== 16'd8) begin
      errors++;
      $display("FAIL drain_count: words %0d count %0d required 8/8", got, beat_count);
    end
  endtask

  task automatic test_toggle;
    logic [15:0] exp [4];
    int got = 0;
    exp[0] = 16'hA5A5; exp[1] = 16'h5A5A; exp[2] = 16'hFFFF; exp[3] = 16'h0000;
    do_reset;
    for (int i = 0; i < 4; i++) push(exp[i]);
    enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      m_ready = ((c % 2) == 0);
      #1;
      checks++;
      if (outstanding > 2 ||
          (fifo_rd_en && (outstanding - int'(m_valid & m_ready)) >= 2)) begin
        errors++;
        $display("FAIL toggle_occupancy: outstanding=%0d rd_en=%b pop=%b", outstanding,
                 fifo_rd_en, m_valid & m_ready);
      end
      if (m_valid && m_ready) begin
        checks++;
        if (got >= 4 || m_data !== exp[got % 4]) begin
          errors++;
          $display("FAIL toggle_order: word %0d got %h required %h", got, m_data, exp[got % 4]);
        end
        got++;
      end
      tick;
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL toggle_count: got %0d words required 4", got);
    end
  endtask

  task automatic test_enable;
    do_reset;
    push(16'h1111); push(16'h2222); push(16'h3333);
    enable = 1'b0; m_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL enable_low: rd_en=%b valid=%b required 0/0", fifo_rd_en, m_valid);
      end
      tick;
    end
    enable = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL enable_rd: rd_en=%b required 1", fifo_rd_en);
    end
    tick;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_early: valid=%b required 0", m_valid);
    end
    tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h1111) begin
      errors++;
      $display("FAIL enable_latency: valid=%b data=%h required 1/1111", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick;
  endtask

  task automatic test_underflow;
    do_reset;
    fifo_underflow = 1'b1;
    tick;
    fifo_underflow = 1'b0;
    checks++;
    if (underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b required 1", underflow_err);
    end
    tick;
    checks++;
    if (underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", underflow_err);
    end
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    checks++;
    if (underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b required 0", underflow_err);
    end
    fifo_underflow = 1'b1; clear_err = 1'b1;
    tick;
    fifo_underflow = 1'b0; clear_err = 1'b0;
    checks++;
    if (underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins: got %b required 1", underflow_err);
    end
  endtask

  task automatic test_reset_midflight;
    do_reset;
    push(16'h0A01); push(16'h0A02); push(16'h0A03);
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick;
    checks++;
    if (beat_count !== 16'd3) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d required 3", beat_count);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    tick; tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0100 || outstanding != 2) begin
      errors++;
      $display("FAIL pre_reset_full: valid=%b data=%h outstanding=%0d required 1/0100/2",
               m_valid, m_data, outstanding);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 16'h0 || fifo_rd_en !== 1'b0 || beat_count !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h rd_en=%b cnt=%0d required all 0",
               m_valid, m_data, fifo_rd_en, beat_count);
    end
    enable = 1'b0; flush = 1'b1;
    tick; tick;
    flush = 1'b0; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_word: valid=%b data=%h required valid 0", m_valid, m_data);
      end
      tick;
    end
  endtask

  task automatic test_count_wrap;
    for (int i = 0; i < 17; i++) push(16'h0200 + 16'(i));
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 24; c++) tick;
    checks++;
    if (beat_count !== 16'd17) begin
      errors++;
      $display("FAIL count_17: got %0d required 17", beat_count);
    end
    checks++;
    if (beat_count4 !== 4'd1) begin
      errors++;
      $display("FAIL count_wrap4: got %0d required 1", beat_count4);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_toggle;
    test_enable;
    test_underflow;
    test_reset_midflight;
    test_count_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
